ecc_point_table_gen: RTL and testbench



---
 rtl/ecc_pkg.sv | 27 ++
 rtl/ecc_pt_ram.sv | 26 ++
 rtl/ecc_point_table_gen.sv | 171 +++++++++++++++++
 tb/tb_ecc_point_table_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types, default curve constants and the modular-reduction helper for the
// prime-field ECC point-table generator.
package ecc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StYsq,
    StX2,
    StRhs,
    StCmp,
    StDone
  } state_e;

  typedef struct packed {
    int unsigned p;
    int unsigned a;
    int unsigned b;
  } curve_t;

  // y^2 = x^3 + x + 2 over GF(11): 15 affine points.
  localparam curve_t ECC_P11_A1_B2 = '{p: 32'd11, a: 32'd1, b: 32'd2};

  function automatic logic [63:0] mod_red(input logic [63:0] value, input int unsigned p);
    return value % 64'(p);
  endfunction

endpackage

// File: rtl/ecc_pt_ram.sv
// Point table storage: DEPTH x 2W words, one write port, one combinational read port.
// Entry 0 always reads as zero (reserved for the point at infinity).
module ecc_pt_ram #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [2*W-1:0]  wdata,
  input  logic [IW-1:0]   raddr,
  output logic [2*W-1:0]  rdata
);

  logic [2*W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/ecc_point_table_gen.sv
// Enumerates the affine points of y^2 = x^3 + A*x + B (mod P) into a table and serves
// indexed lookups. Optional macro ECC_PT_NEG_EN adds a pt_neg input returning -P.
module ecc_point_table_gen
  import ecc_pkg::*;
#(
  parameter int unsigned P     = ECC_P11_A1_B2.p,
  parameter int unsigned A     = ECC_P11_A1_B2.a,
  parameter int unsigned B     = ECC_P11_A1_B2.b,
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          built,
  output logic [IW:0]   count,
  output logic          overflow,
  input  logic [IW-1:0] idx,
  input  logic          idx_valid,
`ifdef ECC_PT_NEG_EN
  input  logic          pt_neg,
`endif
  output logic          idx_ready,
  output logic [W-1:0]  pt_x,
  output logic [W-1:0]  pt_y,
  output logic          pt_inf,
  output logic          pt_valid
);

  localparam int unsigned RW = 2 * W + 2;

  state_e         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [W-1:0]   ysq_q, ysq_d, x2_q, x2_d, rhs_q, rhs_d;
  logic [IW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           we, accept, lookup_inf, neg;
  logic [RW-1:0]  rhs_wide;
  logic [2*W-1:0] rd_data;
  logic [W-1:0]   rd_x, rd_y, y_out;

  // Full-width sum so the reduction sees the exact value.
  assign rhs_wide = RW'(x2_q) * RW'(x_q) + RW'(A) * RW'(x_q) + RW'(B);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    ysq_d      = ysq_q;
    x2_d       = x2_q;
    rhs_d      = rhs_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          count_d    = (IW+1)'(1);
          overflow_d = 1'b0;
          x_d        = '0;
          y_d        = '0;
          state_d    = StYsq;
        end
      end
      StYsq: begin
        ysq_d   = W'(mod_red(64'(y_q) * 64'(y_q), P));
        state_d = StX2;
      end
      StX2: begin
        x2_d    = W'(mod_red(64'(x_q) * 64'(x_q), P));
        state_d = StRhs;
      end
      StRhs: begin
        rhs_d   = W'(mod_red(64'(rhs_wide), P));
        state_d = StCmp;
      end
      StCmp: begin
        if (rhs_q == ysq_q) begin
          if (count_q < (IW+1)'(DEPTH)) begin
            we      = 1'b1;
            count_d = count_q + (IW+1)'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (x_q != W'(P - 1)) begin
          x_d     = x_q + W'(1);
          state_d = StX2;
        end else if (y_q != W'(P - 1)) begin
          x_d     = '0;
          y_d     = y_q + W'(1);
          state_d = StYsq;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      ysq_q      <= '0;
      x2_q       <= '0;
      rhs_q      <= '0;
      count_q    <= (IW+1)'(1);
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ysq_q      <= ysq_d;
      x2_q       <= x2_d;
      rhs_q      <= rhs_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  ecc_pt_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[IW-1:0]),
    .wdata ({x_q, y_q}),
    .raddr (idx),
    .rdata (rd_data)
  );

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign built     = (state_q == StDone);
  assign idx_ready = built;
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign accept     = idx_valid && built;
  assign lookup_inf = (idx == '0) || ({1'b0, idx} >= count_q);
  assign rd_x       = rd_data[2*W-1:W];
  assign rd_y       = rd_data[W-1:0];
`ifdef ECC_PT_NEG_EN
  assign neg = pt_neg;
`else
  assign neg = 1'b0;
`endif
  assign y_out = (neg && (rd_y != '0)) ? W'(P) - rd_y : rd_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_valid <= 1'b0;
      pt_inf   <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
    end else begin
      pt_valid <= accept;
      if (accept) begin
        pt_inf <= lookup_inf;
        pt_x   <= lookup_inf ? '0 : rd_x;
        pt_y   <= lookup_inf ? '0 : y_out;
      end
    end
  end

endmodule

// File: tb/tb_ecc_point_table_gen.sv
// Self-checking bench: curve-point model, per-cycle compare of two instances (DEPTH 32 and 8).
module tb_ecc_point_table_gen;

  localparam int P = 11;
  localparam int A = 1;
  localparam int B = 2;
  localparam int BUILD_CYC = P * (1 + 3 * P);
`ifdef ECC_PT_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       idx_valid = 1'b0;
  logic       pt_neg = 1'b0;
  logic [4:0] idx = '0;

  logic       busy0, built0, ovf0, rdy0, inf0, v0;
  logic [5:0] count0;
  logic [4:0] x0, y0;
  logic       busy1, built1, ovf1, rdy1, inf1, v1;
  logic [3:0] count1;
  logic [4:0] x1, y1;

  always #5 clk = ~clk;

  ecc_point_table_gen #(
    .P(11), .A(1), .B(2), .W(5), .DEPTH(32), .IW(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .built(built0), .count(count0),
    .overflow(ovf0), .idx(idx), .idx_valid(idx_valid),
`ifdef ECC_PT_NEG_EN
    .pt_neg(pt_neg),
`endif
    .idx_ready(rdy0), .pt_x(x0), .pt_y(y0), .pt_inf(inf0), .pt_valid(v0)
  );

  ecc_point_table_gen #(
    .P(11), .A(1), .B(2), .W(5), .DEPTH(8), .IW(3)
  ) dut8 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .built(built1), .count(count1),
    .overflow(ovf1), .idx(idx[2:0]), .idx_valid(idx_valid),
`ifdef ECC_PT_NEG_EN
    .pt_neg(pt_neg),
`endif
    .idx_ready(rdy1), .pt_x(x1), .pt_y(y1), .pt_inf(inf1), .pt_valid(v1)
  );

  int tests = 0;
  int fails = 0;
  int px[$];
  int py[$];
  int phase = 0;  // 0 idle, 1 building, 2 table valid
  int remain = 0;
  bit pend_v[2];
  bit pend_inf[2];
  int pend_x[2];
  int pend_y[2];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int depth);
    return (px.size() + 1 < depth) ? px.size() + 1 : depth;
  endfunction

  task automatic expect_pt(input int depth, input int i, input bit n,
                           output bit inf, output int ex, output int ey);
    if (i == 0 || i >= exp_cnt(depth)) begin
      inf = 1'b1; ex = 0; ey = 0;
    end else begin
      inf = 1'b0;
      ex  = px[i-1];
      ey  = (n && py[i-1] != 0) ? P - py[i-1] : py[i-1];
    end
  endtask

  task automatic cmp_dut(input int d, input int depth, input int busy_a, input int built_a,
                         input int cnt_a, input int ovf_a, input int rdy_a, input int v_a,
                         input int x_a, input int y_a, input int inf_a);
    string t;
    t = $sformatf("d%0d", depth);
    check({t, "_busy"}, busy_a, int'(phase == 1));
    check({t, "_built"}, built_a, int'(phase == 2));
    check({t, "_idx_ready"}, rdy_a, int'(phase == 2));
    if (phase == 0) begin
      check({t, "_count_idle"}, cnt_a, 1);
      check({t, "_overflow_idle"}, ovf_a, 0);
    end else if (phase == 2) begin
      check({t, "_count_done"}, cnt_a, exp_cnt(depth));
      check({t, "_overflow_done"}, ovf_a, int'(px.size() > depth - 1));
    end
    check({t, "_pt_valid"}, v_a, int'(pend_v[d]));
    if (pend_v[d]) begin
      check({t, "_pt_inf"}, inf_a, int'(pend_inf[d]));
      check({t, "_pt_x"}, x_a, pend_x[d]);
      check({t, "_pt_y"}, y_a, pend_y[d]);
    end
  endtask

  // Compare process: checks both instances every cycle, then advances the model.
  always @(negedge clk) begin
    bit n;
    if (rst) begin
      phase = 0;
      pend_v[0] = 1'b0;
      pend_v[1] = 1'b0;
    end
    cmp_dut(0, 32, busy0, built0, count0, ovf0, rdy0, v0, x0, y0, inf0);
    cmp_dut(1, 8, busy1, built1, count1, ovf1, rdy1, v1, x1, y1, inf1);
    if (!rst) begin
      n = NEG_EN && pt_neg;
      pend_v[0] = idx_valid && phase == 2;
      pend_v[1] = pend_v[0];
      if (pend_v[0]) begin
        expect_pt(32, int'(idx), n, pend_inf[0], pend_x[0], pend_y[0]);
        expect_pt(8, int'(idx[2:0]), n, pend_inf[1], pend_x[1], pend_y[1]);
      end
      if (phase != 1 && start) begin
        phase  = 1;
        remain = BUILD_CYC;
      end else if (phase == 1) begin
        remain--;
        if (remain == 0) phase = 2;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic measure_build(input string name);
    int n;
    n = 0;
    while (busy0 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, BUILD_CYC);
  endtask

  task automatic wait_built(input string name);
    for (int k = 0; k < 500 && !built0; k++) begin
      @(posedge clk); #1;
    end
    check(name, built0, 1);
  endtask

  task automatic chk_reset(input string name);
    check({name, "_busy"}, busy0, 0);
    check({name, "_built"}, built0, 0);
    check({name, "_count"}, count0, 1);
    check({name, "_overflow"}, ovf0, 0);
    check({name, "_pt_valid"}, v0, 0);
    check({name, "_pt_xy"}, {x0, y0}, 0);
    check({name, "_pt_inf"}, inf0, 0);
  endtask

  task automatic lit_lookup(input string name, input int i, input bit n,
                            input bit einf, input int ex, input int ey);
    idx = 5'(i);
    pt_neg = n;
    idx_valid = 1'b1;
    @(posedge clk); #1;
    idx_valid = 1'b0;
    pt_neg = 1'b0;
    check({name, "_valid"}, v0, 1);
    check({name, "_inf"}, inf0, int'(einf));
    check({name, "_x"}, x0, ex);
    check({name, "_y"}, y0, ey);
  endtask

  initial begin
    for (int y = 0; y < P; y++) begin
      for (int x = 0; x < P; x++) begin
        if ((x * x * x + A * x + B) % P == (y * y) % P) begin
          px.push_back(x);
          py.push_back(y);
        end
      end
    end
    // Hand-derived anchors for the model itself.
    check("model_npts", px.size(), 15);
    check("model_pt1", px[0] * 100 + py[0], 500);
    check("model_pt4", px[3] * 100 + py[3], 201);
    check("model_pt8", px[7] * 100 + py[7], 804);
    check("model_pt15", px[14] * 100 + py[14], 210);

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("idle");

    // Lookup held during the build: answered one cycle after built rises.
    idx = 5'd4;
    idx_valid = 1'b1;
    pulse_start();
    measure_build("build_cycles");
    check("built_rise", built0, 1);
    @(posedge clk); #1;
    check("held_lookup_valid", v0, 1);
    check("held_lookup_xy", {x0, y0}, {5'd2, 5'd1});
    idx_valid = 1'b0;
    @(posedge clk); #1;
    check("count32", count0, 16);
    check("ovf32", ovf0, 0);
    check("count8", count1, 8);
    check("ovf8", ovf1, 1);

    lit_lookup("idx1", 1, 1'b0, 1'b0, 5, 0);
    lit_lookup("idx4", 4, 1'b0, 1'b0, 2, 1);
    lit_lookup("idx8", 8, 1'b0, 1'b0, 8, 4);
    lit_lookup("idx15", 15, 1'b0, 1'b0, 2, 10);
    lit_lookup("idx0", 0, 1'b0, 1'b1, 0, 0);
    lit_lookup("idx16", 16, 1'b0, 1'b1, 0, 0);
    lit_lookup("idx6", 6, 1'b0, 1'b0, 4, 2);
    check("d8_idx6_xy", {x1, y1}, {5'd4, 5'd2});
`ifdef ECC_PT_NEG_EN
    lit_lookup("neg_idx4", 4, 1'b1, 1'b0, 2, 10);
    lit_lookup("neg_idx2", 2, 1'b1, 1'b0, 7, 0);
    lit_lookup("neg_idx0", 0, 1'b1, 1'b1, 0, 0);
`endif

    // Random lookups; a rebuild starts mid-stream together with an accepted lookup.
    for (int c = 0; c < 300; c++) begin
      idx = 5'($urandom_range(0, 31));
      idx_valid = 1'($urandom_range(0, 1));
      pt_neg = 1'($urandom_range(0, 1));
      start = (c == 100);
      if (c == 100) idx_valid = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    idx_valid = 1'b0;
    wait_built("rebuild_done");
    for (int c = 0; c < 100; c++) begin
      idx = 5'($urandom_range(0, 31));
      idx_valid = 1'($urandom_range(0, 1));
      pt_neg = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    idx_valid = 1'b0;
    pt_neg = 1'b0;

    // Reset in the middle of a build, then a clean rebuild.
    pulse_start();
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset("midbuild_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start();
    measure_build("rebuild_cycles");
    check("rebuild_count", count0, 16);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
